// File: rtl/skrach_osc_stream_pkg.sv
// Shared types, constants and arithmetic helpers for the skrach oscillator stream.
// Latency: n/a (package only).
// Backpressure: n/a (package only). Noise helpers are used only when SKRACH_OSC_NOISE_EN is defined.
package skrach_osc_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  // Raw waveform samples are always 16-bit signed before the gain stage.
  localparam int          RAW_W     = 16;
  localparam logic [15:0] AMP_UNITY = 16'h8000;
  localparam logic [15:0] SQ_POS    = 16'h7FFF;
  localparam logic [15:0] SQ_NEG    = 16'h8001;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Gains above unity are pulled back to unity so the gain stage can never overflow.
  function automatic logic [15:0] amp_clamp(input logic [15:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

  // One right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // (raw * amp) >>> 15 with amp treated as unsigned; 33-bit product keeps full precision.
  function automatic logic [RAW_W-1:0] gain_scale(input logic signed [RAW_W-1:0] raw,
                                                  input logic [15:0] amp);
    logic signed [32:0] prod;
    prod = raw * $signed({1'b0, amp});
    return prod[30:15];
  endfunction

endpackage

// File: rtl/skrach_osc_stream_if.sv
// AXI4-Stream style sample channel between the oscillator and the DAC/I2S path.
// Latency: none (wires only).
// Backpressure: consumer holds tready low; producer keeps tdata stable while tvalid && !tready.
interface skrach_osc_stream_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/skrach_osc_stream_wave.sv
// Phase accumulator and raw waveform register stage (saw/square/triangle, optional LFSR noise).
// Latency: one cycle from an enabled tick to raw_vld_o; noise needs SKRACH_OSC_NOISE_EN, else wave 3 is silent.
// Backpressure: none; the stage always accepts a tick, the downstream output register decides on drops.
module skrach_osc_wave
  import skrach_osc_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               enable_i,
  input  wave_t              wave_i,
  input  logic [PHASE_W-1:0] tuning_i,
  output logic [RAW_W-1:0]   raw_o,
  output logic               raw_vld_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [RAW_W-1:0]   raw_q, raw_d;
  logic               raw_vld_q;
  logic [RAW_W-1:0]   tri_u;
  logic [RAW_W-1:0]   noise_raw;

`ifdef SKRACH_OSC_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Next LFSR state doubles as the noise sample for the tick that advances it.
  always_comb begin
    lfsr_d    = lfsr_step(lfsr_q);
    noise_raw = lfsr_d;
  end

  // LFSR steps once per enabled tick, independent of the selected waveform.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (tick_i && enable_i) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign noise_raw = '0;
`endif

  // Waveform is derived from the post-increment phase; disable parks the phase at zero.
  always_comb begin
    phase_d = enable_i ? (phase_q + tuning_i) : '0;
    tri_u   = phase_d[PHASE_W-1] ? ~phase_d[PHASE_W-2 -: RAW_W] : phase_d[PHASE_W-2 -: RAW_W];
    raw_d   = '0;
    case (wave_i)
      WAVE_SAW:    raw_d = phase_d[PHASE_W-1 -: RAW_W] ^ 16'h8000;
      WAVE_SQUARE: raw_d = phase_d[PHASE_W-1] ? SQ_NEG : SQ_POS;
      WAVE_TRI:    raw_d = tri_u ^ 16'h8000;
      WAVE_NOISE:  raw_d = noise_raw;
      default:     raw_d = '0;
    endcase
  end

  // Phase moves only on ticks; a raw sample is captured only on enabled ticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= '0;
      raw_q     <= '0;
      raw_vld_q <= 1'b0;
    end else begin
      raw_vld_q <= tick_i && enable_i;
      if (tick_i) begin
        phase_q <= phase_d;
      end
      if (tick_i && enable_i) begin
        raw_q <= raw_d;
      end
    end
  end

  assign raw_o     = raw_q;
  assign raw_vld_o = raw_vld_q;

endmodule

// File: rtl/skrach_osc_stream.sv
// Audio-rate oscillator: shadow config, sample-tick divider, wave stage, gain stage, single-entry stream output.
// Latency: tick in cycle T -> gain result at T+2 -> tvalid from T+3; SKRACH_OSC_NOISE_EN adds LFSR noise on wave 3.
// Backpressure: output holds its sample while tready is low; newer samples are dropped and counted in overrun_cnt.
module skrach_osc_stream
  import skrach_osc_pkg::*;
#(
  parameter int PHASE_W  = 32,
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 2267,  // must be >= 4 so at most one sample is ever in flight
  parameter int OVR_W    = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cfg_update,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_wave,
  input  logic [PHASE_W-1:0]   cfg_tuning,
  input  logic [15:0]          cfg_amp,
  skrach_osc_stream_if.master  m_axis,
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]   cnt_q;
  logic               tick;

  logic               en_q;
  wave_t              wave_q;
  logic [PHASE_W-1:0] tuning_q;
  logic [15:0]        amp_q;
  logic [15:0]        s1_amp_q;

  logic [RAW_W-1:0]   raw;
  logic               raw_vld;
  logic [RAW_W-1:0]   s2_dat_q;
  logic               s2_vld_q;

  logic [SAMPLE_W-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic                load;
  logic                drop;

  assign tick = (cnt_q == CNT_LAST);

  // Free-running sample divider, counts regardless of enable.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Shadow config; a tick in the same cycle still sees the old values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en_q     <= 1'b0;
      wave_q   <= WAVE_SAW;
      tuning_q <= '0;
      amp_q    <= AMP_UNITY;
    end else if (cfg_update) begin
      en_q     <= cfg_enable;
      wave_q   <= wave_t'(cfg_wave);
      tuning_q <= cfg_tuning;
      amp_q    <= amp_clamp(cfg_amp);
    end
  end

  skrach_osc_wave #(
    .PHASE_W (PHASE_W)
  ) u_wave (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .tick_i    (tick),
    .enable_i  (en_q),
    .wave_i    (wave_q),
    .tuning_i  (tuning_q),
    .raw_o     (raw),
    .raw_vld_o (raw_vld)
  );

  // Gain travels alongside the raw sample so a later cfg_update cannot rescale it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_amp_q <= AMP_UNITY;
    end else if (tick) begin
      s1_amp_q <= amp_q;
    end
  end

  // Gain stage register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s2_dat_q <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= raw_vld;
      if (raw_vld) begin
        s2_dat_q <= gain_scale($signed(raw), s1_amp_q);
      end
    end
  end

  assign load = s2_vld_q && (!tvalid_q || m_axis.tready);
  assign drop = s2_vld_q && tvalid_q && !m_axis.tready;

  // Output slot: replace on empty or completing handshake, otherwise drop and count.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovr_d    = ovr_q;
    if (load) begin
      tdata_d  = SAMPLE_W'($signed(s2_dat_q));
      tvalid_d = 1'b1;
    end else if (m_axis.tready) begin
      tvalid_d = 1'b0;
    end
    if (drop && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  // Output and overrun registers; reset discards any held sample.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_skrach_osc_stream.sv
// Scoreboard bench for skrach_osc_stream with CLK_DIV=4.
// Latency: expectations are order-only; sample spacing is checked separately.
// Backpressure: tready is driven per scenario; wave 3 expectations follow SKRACH_OSC_NOISE_EN.
module tb_skrach_osc_stream;
  import skrach_osc_pkg::*;

  localparam int CLK_DIV = 4;

  logic        ACLK;
  logic        ARESET;
  logic        cfg_update;
  logic        cfg_enable;
  logic [1:0]  cfg_wave;
  logic [31:0] cfg_tuning;
  logic [15:0] cfg_amp;
  logic [15:0] overrun_cnt;

  skrach_osc_stream_if #(.SAMPLE_W(16)) axis ();

  skrach_osc_stream #(
    .PHASE_W (32),
    .SAMPLE_W(16),
    .CLK_DIV (CLK_DIV),
    .OVR_W   (16)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .cfg_update (cfg_update),
    .cfg_enable (cfg_enable),
    .cfg_wave   (cfg_wave),
    .cfg_tuning (cfg_tuning),
    .cfg_amp    (cfg_amp),
    .m_axis     (axis),
    .overrun_cnt(overrun_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          hs_cnt   = 0;
  int          cyc      = 0;
  int          last_hs  = 0;
  bit          have_last = 0;
  bit          spacing_en = 0;
  int          hs0;
  bit          hit;

  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed handshake pops one expected sample.
  always @(negedge ACLK) begin
    if (!ARESET && axis.tvalid && axis.tready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got 0x%0h expected none", axis.tdata);
      end else begin
        check("sample", {16'h0, axis.tdata}, {16'h0, exp_q.pop_front()});
      end
      if (spacing_en && have_last) check("spacing", cyc - last_hs, CLK_DIV);
      last_hs   = cyc;
      have_last = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET     = 1'b1;
    cfg_update = 1'b0;
    step(1);
    ARESET     = 1'b0;
    exp_q.delete();
    have_last  = 1'b0;
    spacing_en = 1'b0;
  endtask

  task automatic cfg(input logic en, input logic [1:0] wv, input logic [31:0] tun,
                     input logic [15:0] amp);
    cfg_enable = en;
    cfg_wave   = wv;
    cfg_tuning = tun;
    cfg_amp    = amp;
    cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1; cfg_update = 1'b0; cfg_enable = 1'b0; cfg_wave = 2'd0;
    cfg_tuning = '0; cfg_amp = 16'h8000; axis.tready = 1'b1;
    step(2);
    ARESET = 1'b0;
    check("reset_tvalid", axis.tvalid, 0);
    check("reset_tdata", axis.tdata, 0);
    check("reset_overrun", overrun_cnt, 0);

    // Saw at unity, 16 samples including the wrap, one per CLK_DIV cycles
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      logic [15:0] v;
      v = 16'((i * 32'h1000) & 32'hFFFF) ^ 16'h8000;
      exp_q.push_back(v);
    end
    spacing_en = 1'b1;
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'h8000);
    drain("saw_drain", 120);
    spacing_en = 1'b0;
    check("saw_overrun", overrun_cnt, 0);

    // Square
    do_reset();
    exp_q = '{16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF};
    cfg(1'b1, 2'd1, 32'h4000_0000, 16'h8000);
    drain("square_drain", 80);

    // Half gain
    do_reset();
    exp_q = '{16'hC800, 16'hD000};
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'h4000);
    drain("gain_half_drain", 40);

    // Gain above unity is clamped
    do_reset();
    exp_q = '{16'h9000, 16'hA000, 16'hB000};
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'hFFFF);
    drain("gain_clamp_drain", 40);

    // Triangle
    do_reset();
    exp_q = '{16'hC000, 16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF};
    cfg(1'b1, 2'd2, 32'h2000_0000, 16'h8000);
    drain("tri_drain", 60);

    // Backpressure across three ticks
    do_reset();
    axis.tready = 1'b0;
    exp_q = '{16'h9000, 16'hC000};
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'h8000);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (overrun_cnt == 16'd2) begin hit = 1'b1; break; end
    end
    check("bp_overrun_seen", hit, 1);
    check("bp_overrun", overrun_cnt, 2);
    check("bp_tvalid", axis.tvalid, 1);
    check("bp_tdata_held", axis.tdata, 16'h9000);
    step(1);
    axis.tready = 1'b1;
    drain("bp_drain", 40);
    check("bp_overrun_after", overrun_cnt, 2);

    // cfg_update coincident with a tick, then disable and phase restart
    do_reset();
    hs0 = hs_cnt;
    exp_q = '{16'h9000, 16'hA000, 16'hC000, 16'hE000};
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'h8000);   // latched in cycle 0
    step(6);                                     // cycle 7 is a tick
    cfg(1'b1, 2'd0, 32'h2000_0000, 16'h8000);
    step(8);                                     // cycle 16, before the next tick
    cfg(1'b0, 2'd0, 32'h2000_0000, 16'h8000);
    step(16);
    check("cfg_timing_queue", exp_q.size(), 0);
    check("disable_no_sample", hs_cnt - hs0, 4);
    exp_q = '{16'hA000, 16'hC000};
    cfg(1'b1, 2'd0, 32'h2000_0000, 16'h8000);
    drain("reenable_drain", 40);

    // Wave 3
    do_reset();
`ifdef SKRACH_OSC_NOISE_EN
    exp_q = '{16'hE270, 16'h7138};
`else
    exp_q = '{16'h0000, 16'h0000};
`endif
    cfg(1'b1, 2'd3, 32'h0, 16'h8000);
    drain("noise_drain", 40);

    // Reset while a sample is held under backpressure
    do_reset();
    axis.tready = 1'b0;
    cfg(1'b1, 2'd0, 32'h1000_0000, 16'h8000);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      if (overrun_cnt != 16'd0) begin hit = 1'b1; break; end
    end
    check("mid_overrun_seen", hit, 1);
    check("mid_tvalid_before", axis.tvalid, 1);
    step(1);
    ARESET = 1'b1;
    step(1);
    ARESET = 1'b0;
    check("mid_tvalid_after", axis.tvalid, 0);
    check("mid_overrun_after", overrun_cnt, 0);
    check("mid_tdata_after", axis.tdata, 0);
    hs0 = hs_cnt;
    axis.tready = 1'b1;
    step(24);
    check("mid_shadow_disabled", hs_cnt - hs0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
